// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage <-> HI/LO multiply/divide unit connection.
// Latency: none (wires only).
// Backpressure: the master holds start/wr_hi/wr_lo off while busy is high.
//
// master: execute stage (drives flush, start, op, a, b, wr_hi, wr_lo, wdata)
// slave : hilo_muldiv_unit (drives busy, done, dbz, hi, lo)
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output flush, start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  flush, start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO writes.
// Latency: start in cycle k -> done in k+1+MUL_CYCLES (mul) or k+1+WIDTH (div).
// Backpressure: busy=1 outside IDLE; start and HI/LO writes are ignored then.
//
// Ports: clk, rst (sync, active-high); bus (slave modport): flush/start/op/a/b in,
// wr_hi/wr_lo/wdata in, busy/done/dbz/hi/lo out.
module hilo_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   a_q;       // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0]   div_d;     // divisor magnitude
    logic [WIDTH-1:0]   div_quo;   // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0]   div_rem;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] mul_pipe [MUL_CYCLES];

    logic               accept, mul_last, div_last, commit;
    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix;

    assign accept   = (state == IDLE) && bus.start && !bus.flush;
    assign mul_last = (state == MUL) && (cnt == CW'(MUL_CYCLES - 1));
    assign div_last = (state == DIV) && (cnt == CW'(WIDTH - 1));
    // Results land on the edge that enters DONE, unless this cycle is flushed.
    assign commit   = (mul_last || div_last) && !bus.flush;

    // Operand preparation from the raw inputs in the accept cycle.
    always_comb begin
        is_signed = ~bus.op[0];
        a_ext = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
        b_ext = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
        // Low 2*WIDTH bits of the extended product are correct for both signednesses.
        prod  = a_ext * b_ext;
        a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One restoring-divide step. Because rem < divisor always holds, the
    // borrow out of rem_diff is exactly "shifted remainder < divisor".
    always_comb begin
        rem_sh   = {div_rem, div_quo[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, div_d};
        ge       = ~rem_diff[WIDTH];
        rem_nxt  = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt  = {div_quo[WIDTH-2:0], ge};
        // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
        quo_fix  = neg_q ? -quo_nxt : quo_nxt;
        rem_fix  = neg_r ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bus.op[1] ? DIV : MUL;
            MUL:     if (mul_last) state_nxt = DONE;
            DIV:     if (div_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            a_q     <= '0;
            div_d   <= '0;
            div_quo <= '0;
            div_rem <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            for (int i = 0; i < MUL_CYCLES; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            if (accept) begin
                cnt     <= '0;
                a_q     <= bus.a;
                div_d   <= b_mag;
                div_quo <= a_mag;
                div_rem <= '0;
                neg_q   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r   <= is_signed && bus.a[WIDTH-1];
                mul_pipe[0] <= prod;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + CW'(1);
            end

            if (state == DIV) begin
                div_rem <= rem_nxt;
                div_quo <= quo_nxt;
            end

            // Product advances one stage per cycle; the last stage is valid
            // in the final MUL cycle.
            for (int i = 1; i < MUL_CYCLES; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end

            if (commit) begin
                if (state == MUL) begin
                    {hi_q, lo_q} <= mul_pipe[MUL_CYCLES-1];
                end else if (div_d == '0) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end else if (state == IDLE) begin
                if (bus.wr_hi) hi_q <= bus.wdata;
                if (bus.wr_lo) lo_q <= bus.wdata;
            end

            dbz_q <= commit && div_last && (div_d == '0);
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
